skeleton_line_drawer: RTL and testbench
=======================================

// Module: skeleton_line_drawer
// PURPOSE
//  Downstream of the SPI frame receiver. Takes the 4 decoded joint points (x_1..y_4) and 4-bit r/g/b.
//  Rasterises the 3-segment pose polyline P1->P2->P3->P4 with Bresenham.
//  Emits one pixel write per accepted handshake to the framebuffer writer.
//  Runs in the system clock domain; frame_valid is already synchronised upstream.
// PARAMETERS
//  COORD_W  10   width of each x/y coordinate
//  H_RES    640  visible width; pixels with x >= H_RES are suppressed
//  V_RES    480  visible height; pixels with y >= V_RES are suppressed
// PORTS
//  clk          in   1         system clock
//  reset        in   1         asynchronous, active-high reset
//  frame_valid  in   1         1-cycle pulse: new point set present on x_*/y_*/r/g/b
//  x_1..x_4     in   COORD_W   joint x coordinates, unsigned
//  y_1..y_4     in   COORD_W   joint y coordinates, unsigned
//  r, g, b      in   4 each    line colour
//  pix_ready    in   1         framebuffer accepts the write this cycle
//  pix_we       out  1         pixel write request
//  pix_x        out  COORD_W   pixel x
//  pix_y        out  COORD_W   pixel y
//  pix_rgb      out  12        {r,g,b}, latched per frame
//  busy         out  1         high from frame accept until DONE exits
//  frame_done   out  1         1-cycle pulse when the last segment completes
//  frame_drop   out  1         1-cycle pulse: frame_valid arrived while busy; that frame is ignored
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, latched points/colour=0. Reset mid-frame aborts immediately (async).
//  FSM states:
//   - IDLE: on frame_valid, latch all points and {r,g,b}, seg=0 -> LOAD.
//   - LOAD (1 cycle): x0,y0 = P[seg]; x1,y1 = P[seg+1]; dx = |x1-x0|; dy = -|y1-y0|;
//     sx/sy = +1/-1; err = dx+dy -> DRAW.
//   - DRAW: present (x0,y0). A pixel advances when it is accepted (pix_we & pix_ready)
//     or when it is suppressed off-screen (pix_we=0, advances unconditionally in 1 cycle).
//     Step: e2 = 2*err; if e2 >= dy {err += dy; x0 += sx}; if e2 <= dx {err += dx; y0 += sy}.
//     If the advanced pixel was the endpoint: seg<2 -> seg++ -> LOAD; seg==2 -> DONE.
//   - DONE (1 cycle): frame_done=1 -> IDLE.
//  Arithmetic: dx, dy, err, e2 are signed COORD_W+2 bits; no overflow for any 10-bit inputs.
//  Endpoints are inclusive. Shared vertices P2 and P3 are written twice.
//  Segment pixel count = max(dx, |dy|) + 1. A degenerate segment (P[i]==P[i+1]) gives 1 pixel.
//  Handshake: while pix_we=1 and pix_ready=0, pix_x/pix_y/pix_rgb hold stable. pix_we stays high.
//  Latency: frame_valid in cycle N -> LOAD in N+1 -> first pix_we in N+2. Each LOAD costs 1 bubble cycle.
//  frame_valid in IDLE is accepted. In any other state it pulses frame_drop and leaves the frame untouched.
//  frame_valid in the DONE cycle is a drop; a new frame is accepted only from IDLE.
//  Inputs x_*/y_*/r/g/b are sampled only at accept; later changes have no effect on the current frame.
//  busy = (state != IDLE).
// STRUCTURE
//  Package skeleton_pkg holds:
//   - COORD_W, H_RES_DEF, V_RES_DEF
//   - typedef struct packed {logic [COORD_W-1:0] x, y;} point_t
//   - typedef logic [11:0] rgb_t
//   - typedef enum {IDLE, LOAD, DRAW, DONE} draw_state_t
//  Sub-module bresenham_step: combinational next (x, y, err) plus an at_end flag from the current
//  (x, y, err, dx, dy, sx, sy, x1, y1). The top holds the FSM, the registers and the handshake.
// TESTING
//  1. Horizontal: P1=(10,20), P2=(14,20), P3=P4=(14,20), pix_ready=1 -> 5 pixels (10..14,20), then 1 + 1.
//     frame_done pulses; 7 writes total.
//  2. Diagonal: P1=(0,0), P2=(3,3), others=(3,3) -> (0,0),(1,1),(2,2),(3,3), then (3,3) twice. First pix_we 2 cycles after frame_valid.
//  3. Backpressure: case 1 with pix_ready low for 3 cycles on the 2nd pixel -> (11,20) held stable for 3 cycles.
//     Sequence unchanged.
//  4. Clipping: P1=(638,5), P2=(642,5) -> writes only x=638,639. Off-screen steps take 1 cycle each.
//     frame_done still pulses.
//  5. Drop: frame_valid again mid-DRAW -> frame_drop=1 for 1 cycle; pixel stream and colour unchanged.
//  6. Reset: assert reset during segment 1 -> pix_we, busy = 0 immediately. Next frame_valid restarts at P1.

Source files
------------

// File: rtl/skeleton_pkg.sv
// Shared types and constants for the skeleton pose line rasteriser.
package skeleton_pkg;

   localparam int unsigned COORD_W   = 10;
   localparam int unsigned ERR_W     = COORD_W + 2;
   localparam int unsigned H_RES_DEF = 640;
   localparam int unsigned V_RES_DEF = 480;

   typedef struct packed {
      logic [COORD_W-1:0] x;
      logic [COORD_W-1:0] y;
   } point_t;

   typedef logic [11:0] rgb_t;
   typedef logic signed [ERR_W-1:0] err_t;

   typedef enum logic [1:0] {IDLE, LOAD, DRAW, DONE} draw_state_t;

   function automatic logic [COORD_W-1:0] abs_diff(input logic [COORD_W-1:0] a,
                                                   input logic [COORD_W-1:0] b);
      return (a >= b) ? a - b : b - a;
   endfunction

endpackage

// File: rtl/skeleton_line_drawer_bresenham_step.sv
// One Bresenham step: next (x, y, err) and whether the current pixel is the segment endpoint.
module bresenham_step
   import skeleton_pkg::*;
(
   input  logic [COORD_W-1:0] x,
   input  logic [COORD_W-1:0] y,
   input  err_t               err,
   input  err_t               dx,
   input  err_t               dy,
   input  logic               sx_neg,
   input  logic               sy_neg,
   input  logic [COORD_W-1:0] x1,
   input  logic [COORD_W-1:0] y1,
   output logic [COORD_W-1:0] x_nxt,
   output logic [COORD_W-1:0] y_nxt,
   output err_t               err_nxt,
   output logic               at_end
);

   localparam logic [COORD_W-1:0] ONE = COORD_W'(1);

   err_t e2;

   always_comb begin
      e2      = err <<< 1;
      x_nxt   = x;
      y_nxt   = y;
      err_nxt = err;
      // Both tests use the pre-step e2; err accumulates both corrections.
      if (e2 >= dy) begin
         err_nxt = err_nxt + dy;
         x_nxt   = sx_neg ? x - ONE : x + ONE;
      end
      if (e2 <= dx) begin
         err_nxt = err_nxt + dx;
         y_nxt   = sy_neg ? y - ONE : y + ONE;
      end
      at_end = (x == x1) && (y == y1);
   end

endmodule

// File: rtl/skeleton_line_drawer.sv
// Rasterises the 3-segment pose polyline P1->P2->P3->P4 into a pixel-write handshake stream.
module skeleton_line_drawer
   import skeleton_pkg::*;
#(
   parameter int unsigned H_RES = H_RES_DEF,
   parameter int unsigned V_RES = V_RES_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               frame_valid,
   input  logic [COORD_W-1:0] x_1,
   input  logic [COORD_W-1:0] y_1,
   input  logic [COORD_W-1:0] x_2,
   input  logic [COORD_W-1:0] y_2,
   input  logic [COORD_W-1:0] x_3,
   input  logic [COORD_W-1:0] y_3,
   input  logic [COORD_W-1:0] x_4,
   input  logic [COORD_W-1:0] y_4,
   input  logic [3:0]         r,
   input  logic [3:0]         g,
   input  logic [3:0]         b,
   input  logic               pix_ready,
   output logic               pix_we,
   output logic [COORD_W-1:0] pix_x,
   output logic [COORD_W-1:0] pix_y,
   output logic [11:0]        pix_rgb,
   output logic               busy,
   output logic               frame_done,
   output logic               frame_drop
);

   localparam logic [COORD_W:0] H_LIM = (COORD_W+1)'(H_RES);
   localparam logic [COORD_W:0] V_LIM = (COORD_W+1)'(V_RES);

   draw_state_t        state_q, state_d;
   point_t             pts_q [4];
   point_t             pts_d [4];
   rgb_t               rgb_q, rgb_d;
   logic [1:0]         seg_q, seg_d;
   logic [COORD_W-1:0] x0_q, x0_d, y0_q, y0_d, x1_q, x1_d, y1_q, y1_d;
   err_t               dx_q, dx_d, dy_q, dy_d, err_q, err_d;
   logic               sx_neg_q, sx_neg_d, sy_neg_q, sy_neg_d;
   logic               pix_we_q, pix_we_d, busy_q, busy_d;
   logic               done_q, done_d, drop_q, drop_d;

   point_t             p_a, p_b;
   logic [COORD_W-1:0] x_nxt, y_nxt;
   err_t               err_nxt;
   logic               at_end;
   logic               advance;

   bresenham_step u_step (
      .x       (x0_q),
      .y       (y0_q),
      .err     (err_q),
      .dx      (dx_q),
      .dy      (dy_q),
      .sx_neg  (sx_neg_q),
      .sy_neg  (sy_neg_q),
      .x1      (x1_q),
      .y1      (y1_q),
      .x_nxt   (x_nxt),
      .y_nxt   (y_nxt),
      .err_nxt (err_nxt),
      .at_end  (at_end)
   );

   always_comb begin
      state_d  = state_q;
      pts_d    = pts_q;
      rgb_d    = rgb_q;
      seg_d    = seg_q;
      x0_d     = x0_q;
      y0_d     = y0_q;
      x1_d     = x1_q;
      y1_d     = y1_q;
      dx_d     = dx_q;
      dy_d     = dy_q;
      err_d    = err_q;
      sx_neg_d = sx_neg_q;
      sy_neg_d = sy_neg_q;
      p_a      = pts_q[seg_q];
      p_b      = pts_q[2'(seg_q + 2'd1)];
      // An off-screen pixel is never presented, so it steps without waiting for ready.
      advance  = pix_ready || !pix_we_q;

      case (state_q)
         IDLE: begin
            if (frame_valid) begin
               pts_d[0] = '{x: x_1, y: y_1};
               pts_d[1] = '{x: x_2, y: y_2};
               pts_d[2] = '{x: x_3, y: y_3};
               pts_d[3] = '{x: x_4, y: y_4};
               rgb_d    = {r, g, b};
               seg_d    = 2'd0;
               state_d  = LOAD;
            end
         end
         LOAD: begin
            x0_d     = p_a.x;
            y0_d     = p_a.y;
            x1_d     = p_b.x;
            y1_d     = p_b.y;
            dx_d     = $signed({2'b00, abs_diff(p_a.x, p_b.x)});
            dy_d     = -$signed({2'b00, abs_diff(p_a.y, p_b.y)});
            err_d    = dx_d + dy_d;
            sx_neg_d = p_b.x < p_a.x;
            sy_neg_d = p_b.y < p_a.y;
            state_d  = DRAW;
         end
         DRAW: begin
            if (advance) begin
               if (at_end) begin
                  if (seg_q == 2'd2) begin
                     state_d = DONE;
                  end else begin
                     seg_d   = seg_q + 2'd1;
                     state_d = LOAD;
                  end
               end else begin
                  x0_d  = x_nxt;
                  y0_d  = y_nxt;
                  err_d = err_nxt;
               end
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase

      pix_we_d = (state_d == DRAW) && ({1'b0, x0_d} < H_LIM) && ({1'b0, y0_d} < V_LIM);
      busy_d   = (state_d != IDLE);
      done_d   = (state_d == DONE);
      drop_d   = frame_valid && (state_q != IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         pts_q    <= '{default: '0};
         rgb_q    <= '0;
         seg_q    <= '0;
         x0_q     <= '0;
         y0_q     <= '0;
         x1_q     <= '0;
         y1_q     <= '0;
         dx_q     <= '0;
         dy_q     <= '0;
         err_q    <= '0;
         sx_neg_q <= 1'b0;
         sy_neg_q <= 1'b0;
         pix_we_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         drop_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         pts_q    <= pts_d;
         rgb_q    <= rgb_d;
         seg_q    <= seg_d;
         x0_q     <= x0_d;
         y0_q     <= y0_d;
         x1_q     <= x1_d;
         y1_q     <= y1_d;
         dx_q     <= dx_d;
         dy_q     <= dy_d;
         err_q    <= err_d;
         sx_neg_q <= sx_neg_d;
         sy_neg_q <= sy_neg_d;
         pix_we_q <= pix_we_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         drop_q   <= drop_d;
      end
   end

   assign pix_we     = pix_we_q;
   assign pix_x      = x0_q;
   assign pix_y      = y0_q;
   assign pix_rgb    = rgb_q;
   assign busy       = busy_q;
   assign frame_done = done_q;
   assign frame_drop = drop_q;

endmodule

// File: tb/tb_skeleton_line_drawer.sv
// Scoreboard bench for skeleton_line_drawer: directed frames with hand-computed pixel streams.
module tb_skeleton_line_drawer;
   import skeleton_pkg::*;

   logic               clk = 1'b0;
   logic               reset;
   logic               frame_valid;
   logic [COORD_W-1:0] x_1, y_1, x_2, y_2, x_3, y_3, x_4, y_4;
   logic [3:0]         r, g, b;
   logic               pix_ready;
   logic               pix_we;
   logic [COORD_W-1:0] pix_x, pix_y;
   logic [11:0]        pix_rgb;
   logic               busy, frame_done, frame_drop;

   typedef struct packed {
      logic [9:0]  x;
      logic [9:0]  y;
      logic [11:0] rgb;
   } exp_t;

   exp_t sb [$];
   exp_t mon_e;
   int   n_chk    = 0;
   int   n_fail   = 0;
   int   n_writes = 0;
   int   w_start  = 0;

   skeleton_line_drawer dut (
      .clk         (clk),
      .reset       (reset),
      .frame_valid (frame_valid),
      .x_1         (x_1),
      .y_1         (y_1),
      .x_2         (x_2),
      .y_2         (y_2),
      .x_3         (x_3),
      .y_3         (y_3),
      .x_4         (x_4),
      .y_4         (y_4),
      .r           (r),
      .g           (g),
      .b           (b),
      .pix_ready   (pix_ready),
      .pix_we      (pix_we),
      .pix_x       (pix_x),
      .pix_y       (pix_y),
      .pix_rgb     (pix_rgb),
      .busy        (busy),
      .frame_done  (frame_done),
      .frame_drop  (frame_drop)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic expect_px(input int x, input int y, input rgb_t c);
      exp_t e;
      e.x   = 10'(x);
      e.y   = 10'(y);
      e.rgb = c;
      sb.push_back(e);
   endtask

   // Horizontal test polyline: 10..14 on row 20, then the shared vertex twice more.
   task automatic expect_h_line(input rgb_t c);
      for (int i = 10; i <= 14; i++) expect_px(i, 20, c);
      expect_px(14, 20, c);
      expect_px(14, 20, c);
   endtask

   task automatic send(input int ax1, input int ay1, input int ax2, input int ay2,
                       input int ax3, input int ay3, input int ax4, input int ay4,
                       input rgb_t c);
      @(posedge clk);
      #1;
      w_start     = n_writes;
      frame_valid = 1'b1;
      x_1 = 10'(ax1); y_1 = 10'(ay1);
      x_2 = 10'(ax2); y_2 = 10'(ay2);
      x_3 = 10'(ax3); y_3 = 10'(ay3);
      x_4 = 10'(ax4); y_4 = 10'(ay4);
      {r, g, b} = c;
      @(posedge clk);
      #1;
      frame_valid = 1'b0;
      {x_1, y_1, x_2, y_2, x_3, y_3, x_4, y_4} = '0;
      {r, g, b} = 12'h000;
   endtask

   task automatic wait_done(input string name, input int exp_cyc, input int exp_writes);
      int n = 0;
      logic seen = 1'b0;
      while (!seen && n < 300) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         seen = frame_done;
      end
      chk({name, "_done"}, 32'(seen), 32'd1);
      if (exp_cyc >= 0) chk({name, "_cycles"}, 32'(n), 32'(exp_cyc));
      @(posedge clk);
      @(negedge clk);
      chk({name, "_done_pulse"}, 32'(frame_done), 32'd0);
      chk({name, "_idle"}, 32'(busy), 32'd0);
      chk({name, "_writes"}, 32'(n_writes - w_start), 32'(exp_writes));
      chk({name, "_sb_empty"}, 32'(sb.size()), 32'd0);
   endtask

   // Monitor: every accepted write is popped against the scoreboard.
   always @(negedge clk) begin
      if (!reset && pix_we && pix_ready) begin
         n_writes++;
         if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_pix: got (%0d,%0d) rgb 0x%0h expected none", pix_x, pix_y, pix_rgb);
         end else begin
            mon_e = sb.pop_front();
            chk("pix", {pix_x, pix_y, pix_rgb}, mon_e);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation bound expired");
      $fatal(1, "timeout");
   end

   initial begin
      reset       = 1'b1;
      frame_valid = 1'b0;
      pix_ready   = 1'b1;
      {x_1, y_1, x_2, y_2, x_3, y_3, x_4, y_4} = '0;
      {r, g, b} = 12'h000;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_pix_we", 32'(pix_we), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(frame_done), 32'd0);
      chk("rst_drop", 32'(frame_drop), 32'd0);
      chk("rst_xy", 32'({pix_x, pix_y}), 32'd0);
      chk("rst_rgb", 32'(pix_rgb), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Horizontal segment plus two degenerate segments
      expect_h_line(12'hABC);
      send(10, 20, 14, 20, 14, 20, 14, 20, 12'hABC);
      wait_done("horiz", 10, 7);

      // Diagonal with first-write latency
      for (int i = 0; i <= 3; i++) expect_px(i, i, 12'h5A5);
      expect_px(3, 3, 12'h5A5);
      expect_px(3, 3, 12'h5A5);
      send(0, 0, 3, 3, 3, 3, 3, 3, 12'h5A5);
      @(negedge clk);
      chk("diag_load_busy", 32'(busy), 32'd1);
      chk("diag_load_we", 32'(pix_we), 32'd0);
      @(posedge clk);
      @(negedge clk);
      chk("diag_first_we", 32'(pix_we), 32'd1);
      chk("diag_first_xy", 32'({pix_x, pix_y}), 32'd0);
      wait_done("diag", 8, 6);

      // Backpressure on the second pixel
      expect_h_line(12'h3C7);
      send(10, 20, 14, 20, 14, 20, 14, 20, 12'h3C7);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      pix_ready = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("hold_we", 32'(pix_we), 32'd1);
         chk("hold_xy", 32'({pix_x, pix_y}), 32'({10'd11, 10'd20}));
         chk("hold_rgb", 32'(pix_rgb), 32'h3C7);
      end
      @(posedge clk);
      #1;
      pix_ready = 1'b1;
      wait_done("bp", -1, 7);

      // Right-edge clipping: off-screen steps take one cycle each
      expect_px(638, 5, 12'hF00);
      expect_px(639, 5, 12'hF00);
      send(638, 5, 642, 5, 642, 5, 642, 5, 12'hF00);
      wait_done("clip", 10, 2);

      // Frame arriving mid-draw is dropped
      expect_h_line(12'h123);
      send(10, 20, 14, 20, 14, 20, 14, 20, 12'h123);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      frame_valid = 1'b1;
      x_1 = 10'd100; y_1 = 10'd100; x_2 = 10'd200; y_2 = 10'd200;
      {r, g, b} = 12'hFFF;
      @(posedge clk);
      #1;
      frame_valid = 1'b0;
      @(negedge clk);
      chk("drop_pulse", 32'(frame_drop), 32'd1);
      @(negedge clk);
      chk("drop_clear", 32'(frame_drop), 32'd0);
      wait_done("drop", -1, 7);

      // Async reset in the second segment, then a clean restart at P1
      for (int i = 10; i <= 14; i++) expect_px(i, 20, 12'h0F0);
      send(10, 20, 14, 20, 14, 20, 14, 20, 12'h0F0);
      repeat (7) @(posedge clk);
      #1;
      chk("pre_rst_busy", 32'(busy), 32'd1);
      reset = 1'b1;
      #1;
      chk("mid_rst_we", 32'(pix_we), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_rgb", 32'(pix_rgb), 32'd0);
      chk("mid_rst_sb", 32'(sb.size()), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      expect_h_line(12'h0F0);
      send(10, 20, 14, 20, 14, 20, 14, 20, 12'h0F0);
      wait_done("restart", 10, 7);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
